// File: rtl/param_rom_stream_ctrl.sv
// Sequencer for a parameter ROM with 2-cycle registered read latency. Sweeps the ROM a
// programmable number of passes per start and presents the words on a valid/ready stream.
module param_rom_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH) + 1,
  parameter int unsigned PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [1:0]            v_q, v_d;
  logic                  done_q, done_d;

  logic stall;
  logic ce;
  logic last_addr;
  logic last_pass;

  // v_q[0]: read register holds a requested word; v_q[1]: ROM output register does.
  assign stall     = v_q[1] & ~data_out_ready;
  assign ce        = (state_q != StIdle) & ~stall;
  assign last_addr = (addr_q == ADDR_WIDTH'(DEPTH - 1));
  assign last_pass = (pass_q == passes_q - PASS_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    v_d      = v_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_passes != '0) begin
            passes_d = num_passes;
            pass_d   = '0;
            addr_d   = '0;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (ce) begin
          v_d = {v_q[0], 1'b1};
          if (!last_addr) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (!last_pass) begin
            addr_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (ce) begin
          v_d = {v_q[0], 1'b0};
          // Pipeline empties on this edge: the final word has just been handed off.
          if (!v_q[0]) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      v_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign rom_addr       = addr_q;
  assign rom_ce         = ce;
  assign data_out       = rom_q;
  assign data_out_valid = v_q[1];

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Directed bench for param_rom_stream_ctrl with a DEPTH=4 ROM model holding 0x10+addr.
module tb_param_rom_stream_ctrl;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned Depth     = 4;
  localparam int unsigned AddrWidth = $clog2(Depth) + 1;
  localparam int unsigned PassWidth = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [PassWidth-1:0] num_passes;
  logic                 busy;
  logic                 done;
  logic [AddrWidth-1:0] rom_addr;
  logic                 rom_ce;
  logic [DataWidth-1:0] rom_q;
  logic [DataWidth-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic [DataWidth-1:0] rom_rd_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_rom_stream_ctrl #(
    .DATA_WIDTH(DataWidth),
    .DEPTH     (Depth),
    .ADDR_WIDTH(AddrWidth),
    .PASS_WIDTH(PassWidth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_passes    (num_passes),
    .busy          (busy),
    .done          (done),
    .rom_addr      (rom_addr),
    .rom_ce        (rom_ce),
    .rom_q         (rom_q),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  // ROM model: read register then output register, both enabled by rom_ce.
  initial begin
    rom_rd_q = '0;
    rom_q    = '0;
  end
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_rd_q <= 16'h0010 + 16'(rom_addr);
      rom_q    <= rom_rd_q;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int p);
    start      = 1'b1;
    num_passes = PassWidth'(p);
    tick();
    start = 1'b0;
  endtask

  // Runs one start command and scoreboards the stream until done; we are in cycle 1 after start.
  task automatic run_stream(input int passes, input bit rand_ready, input bit extra_start);
    int idx = 0;
    int dn = 0;
    bit seen_done = 0;
    do_start(passes);
    for (int cyc = 1; cyc < 600; cyc++) begin
      data_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start          = extra_start && (cyc == 3);
      num_passes     = 8'd1;
      #1;
      if (data_out_valid && data_out_ready) begin
        check("word_data", 32'(data_out), 32'(16'h0010 + 16'(idx % Depth)));
        if (!rand_ready) check("word_cycle", cyc, idx + 3);
        idx++;
      end
      if (done) begin
        dn++;
        if (!rand_ready) check("done_cycle", cyc, Depth * passes + 3);
        check("busy_at_done", 32'(busy), 0);
        seen_done = 1;
        break;
      end
      tick();
    end
    start = 1'b0;
    check("run_done_seen", 32'(seen_done), 1);
    check("word_count", idx, Depth * passes);
    for (int k = 0; k < 4; k++) begin
      tick();
      data_out_ready = 1'b1;
      #1;
      if (done) dn++;
      check("idle_after", {busy, rom_ce, data_out_valid}, 0);
    end
    check("done_count", dn, 1);
  endtask

  // Backpressure expectations for cycles 1..10: {rom_ce, rom_addr, valid, done} and data.
  logic [5:0]  bp_ctl  [1:10];
  logic [15:0] bp_data [1:10];

  initial begin
    bp_ctl[1]  = {1'b1, 3'd0, 1'b0, 1'b0};
    bp_ctl[2]  = {1'b1, 3'd1, 1'b0, 1'b0};
    bp_ctl[3]  = {1'b1, 3'd2, 1'b1, 1'b0};
    bp_ctl[4]  = {1'b0, 3'd3, 1'b1, 1'b0};
    bp_ctl[5]  = {1'b0, 3'd3, 1'b1, 1'b0};
    bp_ctl[6]  = {1'b0, 3'd3, 1'b1, 1'b0};
    bp_ctl[7]  = {1'b1, 3'd3, 1'b1, 1'b0};
    bp_ctl[8]  = {1'b1, 3'd3, 1'b1, 1'b0};
    bp_ctl[9]  = {1'b1, 3'd3, 1'b1, 1'b0};
    bp_ctl[10] = {1'b0, 3'd3, 1'b0, 1'b1};
    bp_data[1] = 16'h0;  bp_data[2] = 16'h0;  bp_data[3] = 16'h10;
    bp_data[4] = 16'h11; bp_data[5] = 16'h11; bp_data[6] = 16'h11;
    bp_data[7] = 16'h11; bp_data[8] = 16'h12; bp_data[9] = 16'h13;
    bp_data[10] = 16'h0;

    rst            = 1'b1;
    start          = 1'b0;
    num_passes     = '0;
    data_out_ready = 1'b1;
    tick();
    tick();
    check("reset_state", {busy, done, data_out_valid, rom_ce, 3'(rom_addr)}, 0);
    rst = 1'b0;
    tick();

    // Single pass, ready high: valid 3..6, done 7, busy 1..6.
    do_start(1);
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("p1_ctl", {busy, done, data_out_valid},
            {1'(k >= 1 && k <= 6), 1'(k == 7), 1'(k >= 3 && k <= 6)});
      if (k >= 3 && k <= 6) check("p1_data", 32'(data_out), 32'(16'h0010 + 16'(k - 3)));
      tick();
    end

    // Three passes, no bubbles across pass wrap.
    run_stream(3, 1'b0, 1'b0);

    // Backpressure: ready low during cycles 4..6.
    do_start(1);
    for (int k = 1; k <= 10; k++) begin
      data_out_ready = !(k >= 4 && k <= 6);
      #1;
      check("bp_ctl", {rom_ce, 3'(rom_addr), data_out_valid, done}, bp_ctl[k]);
      if (bp_ctl[k][1]) check("bp_data", 32'(data_out), 32'(bp_data[k]));
      tick();
    end
    data_out_ready = 1'b1;
    tick();

    // Zero passes: only a done pulse.
    do_start(0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("zero_pass", {busy, done, data_out_valid, rom_ce}, {1'b0, 1'(k == 1), 2'b00});
      tick();
    end

    // Reset in cycle 5 of a 2-pass run, then a clean run.
    do_start(2);
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_reset", {busy, done, data_out_valid, rom_ce, 3'(rom_addr)}, 0);
    tick();
    run_stream(1, 1'b0, 1'b0);

    // Random ready over five passes, with a start pulsed while busy.
    run_stream(5, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
